scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
Parametrised registered binary-to-one-hot decoder with enable. It has two modes: direct decode of a select input, and autonomous round-robin scanning with a programmable dwell time. It drives one-hot strobes such as display digit enables, LED columns or chip selects in lab designs. It generalises the combinational 2-to-4 enable decoder to 2**SEL_W outputs and adds registered outputs, a scan sequencer and a wrap indicator.

Parameters:
SEL_W, 2, select/index width; output count N = 2**SEL_W (legal 1..5)
DWELL_W, 8, width of dwell counter and dwell input

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces all outputs inactive
mode  input  1  0 = direct decode, 1 = auto-scan
sel  input  SEL_W  select value used in direct mode
dwell  input  DWELL_W  scan mode: each output stays active dwell+1 cycles
y  output  2**SEL_W  registered one-hot output (all-zero when inactive)
idx  output  SEL_W  registered index of the active output
active  output  1  registered; 1 when y is one-hot, 0 when y is all-zero
wrap  output  1  registered one-cycle pulse when scan index goes N-1 -> 0

Behaviour:
- Reset (rst_n=0, asynchronous): y=0, idx=0, active=0, wrap=0, dwell counter cnt=0, state=IDLE. Release is sampled on the first clk edge with rst_n=1.
- All outputs are registered and updated on the same edge. y always equals active ? (1<<idx) : 0. Output y is never multi-hot.
- States: IDLE, DIRECT, SCAN. Next state is evaluated every edge:
  - en=0 -> IDLE
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
- IDLE: active=0, y=0, wrap=0. idx and cnt hold their values.
- DIRECT: on each edge, idx<=sel, active<=1, wrap<=0, cnt<=0. Latency is 1 cycle from sel/en change to y.
- SCAN entry (previous state IDLE or DIRECT): idx<=0, cnt<=0, active<=1, wrap<=0. The entry cycle counts as the first dwell cycle of output 0.
- SCAN steady state:
  - If cnt >= dwell: cnt<=0 and idx<=idx+1 (modulo N).
  - Otherwise cnt<=cnt+1 and idx holds.
  - wrap<=1 only on the edge where idx goes from N-1 to 0; otherwise wrap<=0.
- dwell=0: index advances every cycle. wrap pulses once every N cycles.
- dwell is sampled live. Lowering it below the current cnt forces an advance on the next edge (the >= compare). Raising it extends the current slot.
- Changing mode mid-operation:
  - 1->0: DIRECT takes effect on the next edge.
  - 0->1: scan restarts at idx 0.
- en deassert mid-scan: y=0 on the next edge. Re-enabling in SCAN restarts at idx 0.
- Reset asserted mid-scan: outputs clear immediately, without waiting for a clock edge.
- wrap is never asserted in IDLE or DIRECT, and is never asserted on SCAN entry.
- Arithmetic: idx increment wraps naturally in SEL_W bits. cnt is DWELL_W bits and cannot overflow because it is compared against dwell.

Test Plan:
- Reset/idle (SEL_W=2): rst_n=0 with en=1 -> y=0000, active=0, wrap=0 immediately. Release with en=0 -> y remains 0000.
- Direct decode (SEL_W=2): en=1, mode=0; sel=0,1,2,3 on consecutive cycles -> y=0001,0010,0100,1000, each one cycle after sel. Drop en -> y=0000 next cycle.
- Scan with dwell=2 (SEL_W=2): from IDLE, set en=1, mode=1 -> y=0001 for 3 cycles, then 0010 x3, 0100 x3, 1000 x3, then 0001. wrap=1 only in the first cycle of the returning 0001 (cycle 13 after entry).
- Scan with dwell=0 (SEL_W=3): y walks 00000001..10000000 on consecutive cycles. wrap pulses every 8 cycles. idx tracks 0..7.
- Mid-operation changes: in SCAN at idx=2, switch mode=0 with sel=1 -> y=0010 next cycle. Switch back to mode=1 -> y=0001, idx=0. Lower dwell from 5 to 1 while cnt=3 -> advance on the next edge.
- Async reset mid-scan: assert rst_n=0 between clock edges -> y=0000, idx=0 without a clock. After release, SCAN restarts at y=0001.

Source files
------------

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
//
// Registered binary-to-one-hot decoder with enable. It has two ways of
// choosing the active output:
//   - direct mode: the active output follows the sel input, one cycle later.
//   - scan mode:   the block walks the outputs round-robin by itself. Each
//                  output stays active for dwell+1 cycles.
// Typical loads are display digit enables, LED columns and chip selects.
//
// Parameters:
//   SEL_W   - index width; the number of outputs is N = 2**SEL_W (1..5)
//   DWELL_W - width of the dwell input and of the internal dwell counter
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   en     in   block enable; 0 forces every output inactive
//   mode   in   0 = direct decode of sel, 1 = auto-scan
//   sel    in   [SEL_W]   index used in direct mode
//   dwell  in   [DWELL_W] scan mode: extra cycles each output is held
//   y      out  [N]       registered one-hot strobe, all-zero when inactive
//   idx    out  [SEL_W]   registered index of the active output
//   active out  registered; 1 when y is one-hot, 0 when y is all-zero
//   wrap   out  registered one-cycle pulse when the scan goes N-1 -> 0
// ---------------------------------------------------------------------------
module scan_decoder #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    active,
    output logic                    wrap
);

    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t               state;
    logic [DWELL_W-1:0]   cnt;
    logic [SEL_W-1:0]     idx_inc;
    logic [N-1:0]         sel_hot;
    logic [N-1:0]         inc_hot;

    // The next scan index simply rolls over in SEL_W bits, which is exactly
    // the modulo-N behaviour we want because N is a power of two. The one-hot
    // patterns are prepared here so the register block can load y together
    // with idx and keep y == (1 << idx) by construction.
    assign idx_inc = idx + SEL_W'(1);
    assign sel_hot = HOT0 << sel;
    assign inc_hot = HOT0 << idx_inc;

    // Single state/output register. The state register holds the mode we
    // were in on the previous cycle; that is what lets us recognise a fresh
    // entry into scan mode (from IDLE, DIRECT or reset) and restart the walk
    // at output 0 with the entry cycle counted as the first dwell cycle.
    // In scan mode, dwell is compared live with >= so that lowering it below
    // the current count forces an advance on the very next edge instead of
    // letting the counter run away. wrap is set only on the advancing edge
    // out of the last output, which is when idx is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            y      <= '0;
            idx    <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
            cnt    <= '0;
        end else if (!en) begin
            state  <= IDLE;
            y      <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else if (!mode) begin
            state  <= DIRECT;
            idx    <= sel;
            y      <= sel_hot;
            active <= 1'b1;
            wrap   <= 1'b0;
            cnt    <= '0;
        end else if (state != SCAN) begin
            state  <= SCAN;
            idx    <= '0;
            y      <= HOT0;
            active <= 1'b1;
            wrap   <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= SCAN;
            active <= 1'b1;
            if (cnt >= dwell) begin
                cnt  <= '0;
                idx  <= idx_inc;
                y    <= inc_hot;
                wrap <= &idx;
            end else begin
                cnt  <= cnt + DWELL_W'(1);
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
//
// Self-checking bench for scan_decoder. Two instances share clock and reset:
// dut2 (SEL_W=2, four outputs) runs a table of directed vectors covering
// reset, direct decode, scan with dwell=2, mode switches and live dwell
// changes; dut3 (SEL_W=3, eight outputs) covers direct decode and a dwell=0
// scan. Inputs change one time unit after the rising edge and outputs are
// sampled one time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;

    logic       en2;
    logic       mode2;
    logic [1:0] sel2;
    logic [7:0] dwell2;
    logic [3:0] y2;
    logic [1:0] idx2;
    logic       active2;
    logic       wrap2;

    logic       en3;
    logic       mode3;
    logic [2:0] sel3;
    logic [7:0] dwell3;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       active3;
    logic       wrap3;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] dwell;
        logic [3:0] exp_y;
        logic [1:0] exp_idx;
        logic       exp_active;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en2),
        .mode   (mode2),
        .sel    (sel2),
        .dwell  (dwell2),
        .y      (y2),
        .idx    (idx2),
        .active (active2),
        .wrap   (wrap2)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en3),
        .mode   (mode3),
        .sel    (sel3),
        .dwell  (dwell3),
        .y      (y3),
        .idx    (idx3),
        .active (active3),
        .wrap   (wrap3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through here so the counters stay honest.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compares all four outputs of the four-output instance.
    task automatic checkDut2(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                             input logic ea, input logic ew);
        checkOutput($sformatf("%s y", tag), 32'(y2), 32'(ey));
        checkOutput($sformatf("%s idx", tag), 32'(idx2), 32'(ei));
        checkOutput($sformatf("%s active", tag), 32'(active2), 32'(ea));
        checkOutput($sformatf("%s wrap", tag), 32'(wrap2), 32'(ew));
    endtask

    // Compares all four outputs of the eight-output instance.
    task automatic checkDut3(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                             input logic ea, input logic ew);
        checkOutput($sformatf("%s y", tag), 32'(y3), 32'(ey));
        checkOutput($sformatf("%s idx", tag), 32'(idx3), 32'(ei));
        checkOutput($sformatf("%s active", tag), 32'(active3), 32'(ea));
        checkOutput($sformatf("%s wrap", tag), 32'(wrap3), 32'(ew));
    endtask

    // Drives one vector into dut2 and advances to the sampling point after
    // the next rising edge.
    task automatic applyStimulus(input vec_t v);
        en2    = v.en;
        mode2  = v.mode;
        sel2   = v.sel;
        dwell2 = v.dwell;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic e, input logic m, input logic [1:0] s, input logic [7:0] d,
                          input logic [3:0] ey, input logic [1:0] ei, input logic ea, input logic ew);
        vec_t v;
        v.en         = e;
        v.mode       = m;
        v.sel        = s;
        v.dwell      = d;
        v.exp_y      = ey;
        v.exp_idx    = ei;
        v.exp_active = ea;
        v.exp_wrap   = ew;
        vecs.push_back(v);
    endtask

    initial begin
        int exp_i;
        logic exp_w;

        rst_n  = 1'b1;
        en2    = 1'b1;
        mode2  = 1'b0;
        sel2   = 2'd0;
        dwell2 = 8'd0;
        en3    = 1'b0;
        mode3  = 1'b0;
        sel3   = 3'd0;
        dwell3 = 8'd0;

        // Reset asserted with en=1 before any clock edge: outputs clear at once.
        #2 rst_n = 1'b0;
        #1;
        checkDut2("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        stepCycle();
        checkDut2("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkDut3("reset_held3", 8'h00, 3'd0, 1'b0, 1'b0);

        // Release with en=0: the block stays idle.
        en2   = 1'b0;
        rst_n = 1'b1;
        stepCycle();
        checkDut2("release_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Direct decode, one cycle latency, then en drop (idx holds).
        addVec(1'b1, 1'b0, 2'd0, 8'd0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(1'b1, 1'b0, 2'd1, 8'd0, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b0, 2'd2, 8'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(1'b1, 1'b0, 2'd3, 8'd0, 4'b1000, 2'd3, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 8'd0, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Scan with dwell=2 from IDLE: three cycles per output.
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 3; r++) begin
                addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'(1 << s), 2'(s), 1'b1, 1'b0);
            end
        end
        // Thirteenth cycle: back at output 0 with the wrap pulse.
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 2'd0, 1'b1, 1'b1);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd2, 4'b0100, 2'd2, 1'b1, 1'b0);

        // At idx=2: switch to direct with sel=1, back to scan, then en drop.
        addVec(1'b1, 1'b0, 2'd1, 8'd2, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd1, 8'd2, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(1'b0, 1'b1, 2'd1, 8'd2, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Re-enter scan with dwell=5, run cnt up to 3, then lower dwell to 1.
        for (int r = 0; r < 4; r++) begin
            addVec(1'b1, 1'b1, 2'd0, 8'd5, 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        addVec(1'b1, 1'b1, 2'd0, 8'd1, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd1, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(1'b1, 1'b1, 2'd0, 8'd1, 4'b0100, 2'd2, 1'b1, 1'b0);

        // Raise dwell to 3 at the start of a slot: the slot lasts four cycles.
        for (int r = 0; r < 3; r++) begin
            addVec(1'b1, 1'b1, 2'd0, 8'd3, 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        addVec(1'b1, 1'b1, 2'd0, 8'd3, 4'b1000, 2'd3, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkDut2($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_idx,
                      vecs[i].exp_active, vecs[i].exp_wrap);
        end

        // Reset pulled low between edges while scanning at idx 3.
        #3 rst_n = 1'b0;
        #1;
        checkDut2("reset_midscan", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        checkDut2("scan_restart", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Eight-output instance: direct decode at the top of the range.
        en2   = 1'b0;
        en3   = 1'b1;
        mode3 = 1'b0;
        sel3  = 3'd5;
        stepCycle();
        checkDut3("d3_sel5", 8'h20, 3'd5, 1'b1, 1'b0);
        sel3 = 3'd7;
        stepCycle();
        checkDut3("d3_sel7", 8'h80, 3'd7, 1'b1, 1'b0);

        // dwell=0 scan: one output per cycle, wrap every eight cycles.
        mode3  = 1'b1;
        dwell3 = 8'd0;
        for (int k = 1; k <= 20; k++) begin
            stepCycle();
            exp_i = (k - 1) % 8;
            exp_w = (k > 1) && (exp_i == 0);
            checkDut3($sformatf("d3_scan%0d", k), 8'(1 << exp_i), 3'(exp_i), 1'b1, exp_w);
        end

        // Disable: outputs clear, index holds.
        en3 = 1'b0;
        stepCycle();
        checkDut3("d3_off", 8'h00, 3'd3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
